// File: rtl/ram_string_writer.sv
`default_nettype none
// ============================================================================
// Module   : ram_string_writer
// Purpose  : Streams 16-bit characters into consecutive RAM words from a base
//            address and closes each string with a NUL terminator word.
// Revision : 1.0  initial release
// ============================================================================
module ram_string_writer #(
    parameter int WORD_SIZE         = 16,
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int MEMORY_SIZE       = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDRESS_BUS_WIDTH-1:0] base_addr,
    input  logic [WORD_SIZE-1:0]         in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic                         we,
    output logic [ADDRESS_BUS_WIDTH-1:0] wr_addr,
    output logic [WORD_SIZE-1:0]         wr_data,
    output logic                         busy,
    output logic                         done,
    output logic [ADDRESS_BUS_WIDTH-1:0] length,
    output logic                         truncated
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_term = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    // One slot word is always reserved for the terminator.
    localparam logic [ADDRESS_BUS_WIDTH-1:0] c_max_chars =
        ADDRESS_BUS_WIDTH'(MEMORY_SIZE - 1);

    logic [1:0]                   r_state;
    logic [1:0]                   w_state_next;
    logic [ADDRESS_BUS_WIDTH-1:0] r_ptr;
    logic [ADDRESS_BUS_WIDTH-1:0] r_length;
    logic [ADDRESS_BUS_WIDTH-1:0] w_length_inc;
    logic [ADDRESS_BUS_WIDTH-1:0] r_wr_addr;
    logic [WORD_SIZE-1:0]         r_wr_data;
    logic                         r_we;
    logic                         r_done;
    logic                         r_truncated;
    logic                         w_accept;
    logic                         w_is_nul;
    logic                         w_at_cap;
    logic                         w_start_ok;

    assign w_accept     = in_valid && (r_state == c_st_run);
    assign w_is_nul     = (in_data == '0);
    assign w_length_inc = r_length + ADDRESS_BUS_WIDTH'(1);
    assign w_at_cap     = (w_length_inc == c_max_chars);
    assign w_start_ok   = start && ((r_state == c_st_idle) || (r_state == c_st_done));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    w_state_next = c_st_run;
                end
            end
            c_st_run: begin
                if (w_accept) begin
                    if (w_is_nul) begin
                        w_state_next = c_st_done;
                    end else if (in_last || w_at_cap) begin
                        w_state_next = c_st_term;
                    end
                end
            end
            c_st_term: begin
                w_state_next = c_st_done;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // Handshake/status outputs decoded straight from the state
    always_comb begin
        in_ready = (r_state == c_st_run);
        busy     = (r_state == c_st_run) || (r_state == c_st_term);
    end

    // Write port and string status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_length    <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
            r_truncated <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_start_ok) begin
                r_ptr       <= base_addr;
                r_length    <= '0;
                r_done      <= 1'b0;
                r_truncated <= 1'b0;
            end
            if (w_accept) begin
                r_we      <= 1'b1;
                r_wr_addr <= r_ptr;
                r_wr_data <= in_data;
                r_ptr     <= r_ptr + ADDRESS_BUS_WIDTH'(1);
                if (w_is_nul) begin
                    r_done <= 1'b1;
                end else begin
                    r_length <= w_length_inc;
                    if (!in_last && w_at_cap) begin
                        r_truncated <= 1'b1;
                    end
                end
            end
            if (r_state == c_st_term) begin
                r_we      <= 1'b1;
                r_wr_addr <= r_ptr;
                r_wr_data <= '0;
                r_ptr     <= r_ptr + ADDRESS_BUS_WIDTH'(1);
                r_done    <= 1'b1;
            end
        end
    end

    assign we        = r_we;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign done      = r_done;
    assign length    = r_length;
    assign truncated = r_truncated;

endmodule
`default_nettype wire

// File: tb/tb_ram_string_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_string_writer
// Purpose  : Directed bench for ram_string_writer with a string-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ram_string_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready, we, busy, done, truncated;
    logic [15:0] wr_addr, wr_data, length;

    int n_vec = 0;
    int n_bad = 0;
    int n_wr  = 0;
    logic [15:0] ram [0:65535];

    ram_string_writer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .length(length), .truncated(truncated)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // String-level model: an open string is collecting characters until it
    // needs its NUL appended; expected write port values follow from that.
    logic        m_open, m_closing;
    logic [15:0] m_ptr;
    logic        e_we, e_done, e_trunc;
    logic [15:0] e_addr, e_data, e_len;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_open = 0; m_closing = 0; m_ptr = 0;
            e_we = 0; e_done = 0; e_trunc = 0; e_addr = 0; e_data = 0; e_len = 0;
        end else begin
            e_we = 0;
            if (!m_open) begin
                if (start) begin
                    m_ptr = base_addr; e_len = 0; e_done = 0; e_trunc = 0;
                    m_open = 1;
                end
            end else if (m_closing) begin
                e_we = 1; e_addr = m_ptr; e_data = 16'h0000; m_ptr = m_ptr + 16'd1;
                e_done = 1; m_open = 0; m_closing = 0;
            end else if (in_valid) begin
                e_we = 1; e_addr = m_ptr; e_data = in_data; m_ptr = m_ptr + 16'd1;
                if (in_data == 16'h0000) begin
                    e_done = 1; m_open = 0;
                end else begin
                    e_len = e_len + 16'd1;
                    if (in_last) begin
                        m_closing = 1;
                    end else if (e_len == 16'd11) begin
                        m_closing = 1; e_trunc = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("we", we, e_we);
        chk("wr_addr", wr_addr, e_addr);
        chk("wr_data", wr_data, e_data);
        chk("done", done, e_done);
        chk("length", length, e_len);
        chk("truncated", truncated, e_trunc);
        chk("in_ready", in_ready, m_open && !m_closing);
        chk("busy", busy, m_open);
    end

    // RAM image built from the DUT write port
    always @(posedge clk) begin
        if (we === 1'b1) begin
            ram[wr_addr] = wr_data;
            n_wr++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr(input logic [15:0] a, input int n);
        for (int i = 0; i < n; i++) ram[a + 16'(i)] = 16'hDEAD;
    endtask

    task automatic do_start(input logic [15:0] b);
        start = 1'b1; base_addr = b;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] ch, input logic last);
        int k;
        k = 0;
        in_valid = 1'b1; in_data = ch; in_last = last;
        while (in_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) begin
            n_vec++; n_bad++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        if (k >= 40) begin
            n_vec++; n_bad++;
            $display("FAIL done_timeout: done stayed %b, required 1", done);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_we", we, 0); chk("rst_busy", busy, 0); chk("rst_ready", in_ready, 0);

        // "HI" at 0x0010
        clr(16'h0010, 4);
        do_start(16'h0010);
        send(16'h0048, 1'b0);
        send(16'h0049, 1'b1);
        wait_done();
        chk("t2_ram10", ram[16'h0010], 16'h0048);
        chk("t2_ram11", ram[16'h0011], 16'h0049);
        chk("t2_ram12", ram[16'h0012], 16'h0000);
        chk("t2_len", length, 2); chk("t2_done", done, 1); chk("t2_trunc", truncated, 0);

        // Capacity: 'A'..'K' fit, 'L' refused
        clr(16'h0000, 13);
        do_start(16'h0000);
        for (int i = 0; i < 11; i++) send(16'h0041 + 16'(i), 1'b0);
        in_valid = 1'b1; in_data = 16'h004C;
        chk("t3_ready_term", in_ready, 0);
        tick();
        chk("t3_ready_done", in_ready, 0);
        in_valid = 1'b0;
        wait_done();
        for (int i = 0; i < 11; i++) chk("t3_ram", ram[16'(i)], 16'h0041 + 32'(i));
        chk("t3_nul", ram[16'h000B], 16'h0000);
        chk("t3_noL", ram[16'h000C], 16'hDEAD);
        chk("t3_len", length, 11); chk("t3_trunc", truncated, 1);

        // Address wrap
        clr(16'hFFFE, 2); clr(16'h0000, 2);
        do_start(16'hFFFE);
        send(16'h0078, 1'b0); send(16'h0079, 1'b0); send(16'h007A, 1'b1);
        wait_done();
        chk("t4_fffe", ram[16'hFFFE], 16'h0078);
        chk("t4_ffff", ram[16'hFFFF], 16'h0079);
        chk("t4_0000", ram[16'h0000], 16'h007A);
        chk("t4_0001", ram[16'h0001], 16'h0000);
        chk("t4_len", length, 3);

        // Explicit NUL terminator, no TERM write
        clr(16'h0020, 3);
        w0 = n_wr;
        do_start(16'h0020);
        send(16'h0061, 1'b0);
        send(16'h0000, 1'b0);
        wait_done();
        tick();
        chk("t5_ram20", ram[16'h0020], 16'h0061);
        chk("t5_ram21", ram[16'h0021], 16'h0000);
        chk("t5_ram22", ram[16'h0022], 16'hDEAD);
        chk("t5_writes", n_wr - w0, 2);
        chk("t5_len", length, 1); chk("t5_done", done, 1);

        // Toggled valid and an ignored start pulse
        clr(16'h0040, 5); clr(16'h0080, 2);
        w0 = n_wr;
        do_start(16'h0040);
        send(16'h0070, 1'b0); tick();
        start = 1'b1; base_addr = 16'h0080; tick(); start = 1'b0;
        send(16'h0071, 1'b0); tick();
        send(16'h0072, 1'b1);
        wait_done();
        chk("t6_writes", n_wr - w0, 4);
        chk("t6_ram40", ram[16'h0040], 16'h0070);
        chk("t6_ram41", ram[16'h0041], 16'h0071);
        chk("t6_ram42", ram[16'h0042], 16'h0072);
        chk("t6_ram43", ram[16'h0043], 16'h0000);
        chk("t6_ram80", ram[16'h0080], 16'hDEAD);
        chk("t6_len", length, 3);
        do_start(16'h0050);
        chk("t6_restart_done", done, 0); chk("t6_restart_len", length, 0);
        send(16'h0000, 1'b0);
        wait_done();

        // Asynchronous reset in the middle of a string
        do_start(16'h0060);
        send(16'h0075, 1'b0);
        in_valid = 1'b1; in_data = 16'h0076;
        #2 rst_n = 1'b0;
        #1;
        chk("t1_we", we, 0); chk("t1_addr", wr_addr, 0); chk("t1_data", wr_data, 0);
        chk("t1_done", done, 0); chk("t1_len", length, 0); chk("t1_trunc", truncated, 0);
        chk("t1_busy", busy, 0); chk("t1_ready", in_ready, 0);
        tick(); tick();
        rst_n = 1'b1;
        w0 = n_wr;
        for (int i = 0; i < 4; i++) tick();
        chk("t1_no_write", n_wr - w0, 0);
        in_valid = 1'b0;
        clr(16'h0070, 3);
        do_start(16'h0070);
        send(16'h0077, 1'b1);
        wait_done();
        chk("t1_after_ram70", ram[16'h0070], 16'h0077);
        chk("t1_after_ram71", ram[16'h0071], 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
